jtg_mst_arbiter: RTL and testbench
==================================

Name: jtg_mst_arbiter

Overview:
- Two-to-one Avalon-MM arbiter for the JTAG subsystem: it shares one downstream 32-bit Avalon-MM master port between the FPGA-side and HPS-side JTAG masters.
- Sits between the fpga_m_master / hps_m_master outputs and the shared interconnect slave.
- Round-robin grant, command lock while downstream stalls, and in-order read-response routing through a requester-ID FIFO.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byteenable width = DATA_W/8
- MAX_PEND, 4, max outstanding reads (ID FIFO depth, power of 2, >=2)
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk_clk  in  1  clock
- reset_reset_n  in  1  reset; synchronous, active-low
- r0_address/r0_read/r0_write/r0_writedata/r0_byteenable  in  ADDR_W/1/1/DATA_W/DATA_W/8  requester 0 command (FPGA JTAG master)
- r0_waitrequest  out  1  requester 0 stall
- r0_readdata  out  DATA_W  requester 0 read data
- r0_readdatavalid  out  1  requester 0 read data valid
- r1_*  same set as r0_*  requester 1 (HPS JTAG master)
- d_address/d_read/d_write/d_writedata/d_byteenable  out  ADDR_W/1/1/DATA_W/DATA_W/8  downstream command
- d_waitrequest  in  1  downstream stall
- d_readdata  in  DATA_W  downstream read data
- d_readdatavalid  in  1  downstream read data valid
- err_spurious_rdv  out  1  sticky: d_readdatavalid arrived with ID FIFO empty
- pend_count  out  $clog2(MAX_PEND)+1  outstanding reads

Behaviour:
- Synchronous, active-low reset (reset_reset_n low at a rising edge of clk_clk). While reset is active:
  - r0_waitrequest and r1_waitrequest are 1.
  - d_read, d_write, all readdatavalid outputs, err_spurious_rdv and pend_count are 0.
  - d_address, d_writedata and d_byteenable are 0.
  - Grant pointer last_grant is reset to 1, so r0 wins the first tie.
- Requester i is "requesting" when ri_read or ri_write is 1; read and write together is illegal (treated as a write).
- States:
  - IDLE: no grant held.
  - LOCKED: grant held because the downstream stalled.
- IDLE grant, combinational, same cycle:
  - One requester active: that requester is granted.
  - Both active: the requester != last_grant is granted.
- The granted command is muxed combinationally onto d_* (zero added latency).
- Granted ri_waitrequest = d_waitrequest; the non-granted requester sees waitrequest = 1.
- IDLE -> LOCKED when the granted command sees d_waitrequest = 1. The grant is frozen until acceptance; the requester must hold its command stable (Avalon rule).
- Acceptance = d_read|d_write asserted with d_waitrequest = 0. On acceptance: last_grant <= granted ID, state -> IDLE. Back-to-back accepts are allowed every cycle.
- Read gating: when pend_count == MAX_PEND, no new read is granted. A write from either requester may still be granted. A requester blocked on a read sees waitrequest = 1 and d_read stays 0.
- ID FIFO:
  - An accepted read pushes the granted ID.
  - d_readdatavalid pops the head and drives r<head>_readdatavalid = 1 with r<head>_readdata = d_readdata in the same cycle (combinational route).
  - The other readdatavalid stays 0; the other readdata holds 0.
- Push and pop in the same cycle: pend_count unchanged, both take effect.
- d_readdatavalid with FIFO empty: response dropped, err_spurious_rdv set to 1 until reset.
- Writes are posted; nothing is pushed to the ID FIFO.
- Reset mid-transfer: all pending state, FIFO contents and lock are discarded. Responses arriving after reset are handled as spurious.

Optional Feature:
- Macro JTG_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in LOCKED and clears on acceptance or on leaving LOCKED.
  - When it reaches TIMEOUT_CYC-1, the arbiter forces completion: d_read/d_write deasserted, granted ri_waitrequest = 0 for one cycle, state -> IDLE.
  - For a read, the arbiter returns ri_readdatavalid = 1 with readdata = 32'hDEAD_BEEF on the next cycle, with no FIFO push.
  - Extra output timeout_evt pulses 1 cycle per event.
- Undefined: no counter, no timeout_evt port; the lock holds indefinitely.

Test Plan:
- Reset: hold reset_reset_n = 0 for 3 cycles with both requesters active -> both waitrequests 1, d_read = d_write = 0, pend_count = 0.
- Contention: r0 and r1 both read, d_waitrequest = 0 -> grants alternate r0, r1, r0, r1. Returned data 0x11, 0x22, 0x33, 0x44 appears on r0, r1, r0, r1 readdatavalid in that order.
- Lock: r1 writes 0xCAFE0001 to 0x100 with d_waitrequest = 1 for 5 cycles while r0 requests -> d_address stays 0x100 and r0_waitrequest stays 1 for all 5 cycles. r0 is granted the cycle after acceptance.
- Full FIFO: issue 4 r0 reads with no responses -> 5th read held (r0_waitrequest = 1, d_read = 0). A write from r1 is still accepted. Returning one response allows the 5th read to issue.
- Simultaneous push and pop at pend_count = 2 -> pend_count stays 2. A spurious d_readdatavalid at pend_count = 0 sets err_spurious_rdv and drives no requester readdatavalid.
- With JTG_ARB_TIMEOUT_EN and TIMEOUT_CYC = 16: r0 read with d_waitrequest stuck at 1 -> after 16 cycles timeout_evt pulses, r0 receives 0xDEADBEEF, and r1 is then granted.

Source files
------------

// File: rtl/jtg_mst_arbiter.sv
// jtg_mst_arbiter: two-to-one Avalon-MM arbiter for the JTAG subsystem.
// Shares one downstream master port between the FPGA-side (r0) and HPS-side (r1) JTAG masters.
// Features:
//   - round-robin grant
//   - command lock while the downstream stalls
//   - in-order read-response routing through a requester-ID FIFO
// Optional macro JTG_ARB_TIMEOUT_EN adds a lock watchdog and the timeout_evt output.
module jtg_mst_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_PEND    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [ADDR_W-1:0]            r0_address,
  input  logic                         r0_read,
  input  logic                         r0_write,
  input  logic [DATA_W-1:0]            r0_writedata,
  input  logic [DATA_W/8-1:0]          r0_byteenable,
  output logic                         r0_waitrequest,
  output logic [DATA_W-1:0]            r0_readdata,
  output logic                         r0_readdatavalid,
  input  logic [ADDR_W-1:0]            r1_address,
  input  logic                         r1_read,
  input  logic                         r1_write,
  input  logic [DATA_W-1:0]            r1_writedata,
  input  logic [DATA_W/8-1:0]          r1_byteenable,
  output logic                         r1_waitrequest,
  output logic [DATA_W-1:0]            r1_readdata,
  output logic                         r1_readdatavalid,
  output logic [ADDR_W-1:0]            d_address,
  output logic                         d_read,
  output logic                         d_write,
  output logic [DATA_W-1:0]            d_writedata,
  output logic [DATA_W/8-1:0]          d_byteenable,
  input  logic                         d_waitrequest,
  input  logic [DATA_W-1:0]            d_readdata,
  input  logic                         d_readdatavalid,
  output logic                         err_spurious_rdv,
  output logic [$clog2(MAX_PEND):0]    pend_count
`ifdef JTG_ARB_TIMEOUT_EN
  ,
  output logic                         timeout_evt
`endif
);

  localparam int unsigned PW = $clog2(MAX_PEND);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] MaxPendC = CW'(MAX_PEND);
  localparam logic [DATA_W-1:0] ToData = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic {StIdle = 1'b0, StLocked = 1'b1} state_e;

  state_e              r_state, w_state_nxt;
  logic                r_last_grant, r_lock_id;
  logic [MAX_PEND-1:0] r_fifo_id;
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_err;

  logic w_full, w_elig0, w_elig1, w_gnt_vld, w_gnt_id;
  logic w_sel_rd, w_sel_wr, w_accept, w_push, w_pop, w_spur, w_head;
  logic w_to_fire, w_to_rdv, w_to_id, w_rt0, w_rt1, w_to0, w_to1;

  // Reads are held back once the ID FIFO is full; writes are posted and always eligible.
  assign w_full  = (r_count == MaxPendC);
  assign w_elig0 = r0_write | (r0_read & ~w_full);
  assign w_elig1 = r1_write | (r1_read & ~w_full);

  // Grant selection: frozen while locked, round-robin on a tie in idle, nothing during reset.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (!reset_reset_n) begin
      w_gnt_vld = 1'b0;
    end else if (r_state == StLocked) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_lock_id;
    end else if (w_elig0 && w_elig1) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = ~r_last_grant;
    end else if (w_elig0) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (w_elig1) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b1;
    end
  end

  // Read together with write is treated as a write.
  assign w_sel_wr = w_gnt_id ? r1_write : r0_write;
  assign w_sel_rd = (w_gnt_id ? r1_read : r0_read) & ~w_sel_wr;

  assign d_write      = w_gnt_vld & w_sel_wr & ~w_to_fire;
  assign d_read       = w_gnt_vld & w_sel_rd & ~w_to_fire;
  assign d_address    = w_gnt_vld ? (w_gnt_id ? r1_address : r0_address) : '0;
  assign d_writedata  = w_gnt_vld ? (w_gnt_id ? r1_writedata : r0_writedata) : '0;
  assign d_byteenable = w_gnt_vld ? (w_gnt_id ? r1_byteenable : r0_byteenable) : '0;

  // A forced timeout completion releases the granted requester regardless of the downstream.
  assign r0_waitrequest = ~(w_gnt_vld & ~w_gnt_id) | (d_waitrequest & ~w_to_fire);
  assign r1_waitrequest = ~(w_gnt_vld & w_gnt_id) | (d_waitrequest & ~w_to_fire);

  assign w_accept = (d_read | d_write) & ~d_waitrequest;
  assign w_push   = w_accept & d_read;
  assign w_pop    = reset_reset_n & d_readdatavalid & (r_count != '0);
  assign w_spur   = reset_reset_n & d_readdatavalid & (r_count == '0);
  assign w_head   = r_fifo_id[r_rptr];

  // Response routing to the requester at the FIFO head (or the timed-out requester).
  assign w_rt0 = w_pop & ~w_head;
  assign w_rt1 = w_pop & w_head;
  assign w_to0 = w_to_rdv & ~w_to_id;
  assign w_to1 = w_to_rdv & w_to_id;
  assign r0_readdatavalid = w_rt0 | w_to0;
  assign r1_readdatavalid = w_rt1 | w_to1;
  assign r0_readdata = w_to0 ? ToData : (w_rt0 ? d_readdata : '0);
  assign r1_readdata = w_to1 ? ToData : (w_rt1 ? d_readdata : '0);

  assign pend_count       = reset_reset_n ? r_count : '0;
  assign err_spurious_rdv = reset_reset_n & r_err;

  // Next-state: lock on a stalled grant, release on acceptance or forced timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (w_gnt_vld && d_waitrequest) w_state_nxt = StLocked;
      StLocked: if (w_accept || w_to_fire) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // State, lock owner and round-robin pointer.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_lock_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle && w_gnt_vld) r_lock_id <= w_gnt_id;
      if (w_accept || w_to_fire) r_last_grant <= w_gnt_id;
    end
  end

  // Requester-ID FIFO, outstanding-read count and sticky spurious-response flag.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_fifo_id <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_id[r_wptr] <= w_gnt_id;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_spur) r_err <= 1'b1;
    end
  end

`ifdef JTG_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_to_rdv, r_to_id;

  assign w_to_fire   = reset_reset_n & (r_state == StLocked) & (r_to_cnt == ToLast);
  assign w_to_rdv    = reset_reset_n & r_to_rdv;
  assign w_to_id     = r_to_id;
  assign timeout_evt = w_to_fire;

  // Lock watchdog; a timed-out read gets a synthetic response one cycle later.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_to_cnt <= '0;
      r_to_rdv <= 1'b0;
      r_to_id  <= 1'b0;
    end else begin
      if (r_state == StLocked && !w_accept && !w_to_fire) r_to_cnt <= r_to_cnt + 1'b1;
      else                                                r_to_cnt <= '0;
      r_to_rdv <= w_to_fire & w_sel_rd;
      r_to_id  <= w_gnt_id;
    end
  end
`else
  logic w_unused_to;
  assign w_to_fire   = 1'b0;
  assign w_to_rdv    = 1'b0;
  assign w_to_id     = 1'b0;
  assign w_unused_to = (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_jtg_mst_arbiter.sv
// Self-checking bench for jtg_mst_arbiter (timeout scenario built only with JTG_ARB_TIMEOUT_EN).
module tb_jtg_mst_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n;
  logic [31:0] r0_address, r0_writedata, r1_address, r1_writedata;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [3:0]  r0_byteenable, r1_byteenable;
  logic        r0_waitrequest, r0_readdatavalid, r1_waitrequest, r1_readdatavalid;
  logic [31:0] r0_readdata, r1_readdata;
  logic [31:0] d_address, d_writedata, d_readdata;
  logic        d_read, d_write, d_waitrequest, d_readdatavalid;
  logic [3:0]  d_byteenable;
  logic        err_spurious_rdv;
  logic [2:0]  pend_count;
`ifdef JTG_ARB_TIMEOUT_EN
  logic        timeout_evt;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  jtg_mst_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_PEND(4), .TIMEOUT_CYC(16)) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .r0_address       (r0_address),
    .r0_read          (r0_read),
    .r0_write         (r0_write),
    .r0_writedata     (r0_writedata),
    .r0_byteenable    (r0_byteenable),
    .r0_waitrequest   (r0_waitrequest),
    .r0_readdata      (r0_readdata),
    .r0_readdatavalid (r0_readdatavalid),
    .r1_address       (r1_address),
    .r1_read          (r1_read),
    .r1_write         (r1_write),
    .r1_writedata     (r1_writedata),
    .r1_byteenable    (r1_byteenable),
    .r1_waitrequest   (r1_waitrequest),
    .r1_readdata      (r1_readdata),
    .r1_readdatavalid (r1_readdatavalid),
    .d_address        (d_address),
    .d_read           (d_read),
    .d_write          (d_write),
    .d_writedata      (d_writedata),
    .d_byteenable     (d_byteenable),
    .d_waitrequest    (d_waitrequest),
    .d_readdata       (d_readdata),
    .d_readdatavalid  (d_readdatavalid),
    .err_spurious_rdv (err_spurious_rdv),
    .pend_count       (pend_count)
`ifdef JTG_ARB_TIMEOUT_EN
    ,
    .timeout_evt      (timeout_evt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r0_read = 1'b1; r0_address = 32'h10;
    r1_write = 1'b1; r1_address = 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp += 5;
      if (r0_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_r0_wait got %b want 1", r0_waitrequest); end
      if (r1_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_r1_wait got %b want 1", r1_waitrequest); end
      if ({d_read, d_write} !== 2'b00) begin n_err++; $display("FAIL reset_d_cmd got %b want 00", {d_read, d_write}); end
      if (pend_count !== 3'd0) begin n_err++; $display("FAIL reset_pend got %0d want 0", pend_count); end
      if (d_address !== 32'h0) begin n_err++; $display("FAIL reset_d_addr got %h want 0", d_address); end
      tick();
    end
    rst_n = 1'b1; r0_read = 1'b0; r1_write = 1'b0;
    tick();
  endtask

  // Drains n responses; the downstream returns the scoreboard head's data and the bench checks routing.
  task automatic test_read_responses(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL sb_empty got 0 want >0"); return; end
      d_readdatavalid = 1'b1; d_readdata = sb[0].data;
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if ((e.id ? r1_readdatavalid : r0_readdatavalid) !== 1'b1) begin
        n_err++; $display("FAIL rsp_valid id=%0d got 0 want 1", e.id);
      end
      if ((e.id ? r0_readdatavalid : r1_readdatavalid) !== 1'b0) begin
        n_err++; $display("FAIL rsp_other_valid id=%0d got 1 want 0", e.id);
      end
      if ((e.id ? r1_readdata : r0_readdata) !== e.data) begin
        n_err++; $display("FAIL rsp_data id=%0d got %h want %h", e.id,
                          e.id ? r1_readdata : r0_readdata, e.data);
      end
      tick();
    end
    d_readdatavalid = 1'b0; d_readdata = '0;
  endtask

  task automatic test_contention();
    logic last = 1'b1;
    logic g;
    r0_read = 1'b1; r0_address = 32'h1000;
    r1_read = 1'b1; r1_address = 32'h2000;
    d_waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g = ~last;
      @(negedge clk);
      n_cmp += 3;
      if (d_read !== 1'b1) begin n_err++; $display("FAIL cont_d_read k=%0d got %b want 1", k, d_read); end
      if ({r1_waitrequest, r0_waitrequest} !== (g ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL cont_grant k=%0d got wait=%b want %b", k,
                          {r1_waitrequest, r0_waitrequest}, g ? 2'b01 : 2'b10);
      end
      if (d_address !== (g ? 32'h2000 : 32'h1000)) begin
        n_err++; $display("FAIL cont_addr k=%0d got %h", k, d_address);
      end
      sb.push_back('{id: g, data: 32'h11 * (k + 1)});
      last = g;
      tick();
    end
    r0_read = 1'b0; r1_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pend_count !== 3'd4) begin n_err++; $display("FAIL cont_pend got %0d want 4", pend_count); end
    tick();
    test_read_responses(4);
  endtask

  task automatic test_lock();
    r1_write = 1'b1; r1_address = 32'h100; r1_writedata = 32'hCAFE0001; r1_byteenable = 4'hF;
    d_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r0_read = (i > 0); r0_address = 32'h200;
      @(negedge clk);
      n_cmp += 3;
      if (d_address !== 32'h100) begin n_err++; $display("FAIL lock_addr i=%0d got %h want 100", i, d_address); end
      if (r0_waitrequest !== 1'b1) begin n_err++; $display("FAIL lock_r0_wait i=%0d got %b want 1", i, r0_waitrequest); end
      if ({d_write, r1_waitrequest} !== 2'b11) begin
        n_err++; $display("FAIL lock_r1 i=%0d got %b want 11", i, {d_write, r1_waitrequest});
      end
      tick();
    end
    d_waitrequest = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (r1_waitrequest !== 1'b0) begin n_err++; $display("FAIL lock_accept got %b want 0", r1_waitrequest); end
    if (d_writedata !== 32'hCAFE0001) begin n_err++; $display("FAIL lock_wdata got %h want cafe0001", d_writedata); end
    tick();
    r1_write = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if ({d_read, r0_waitrequest} !== 2'b10) begin
      n_err++; $display("FAIL lock_r0_next got %b want 10", {d_read, r0_waitrequest});
    end
    if (d_address !== 32'h200) begin n_err++; $display("FAIL lock_r0_addr got %h want 200", d_address); end
    sb.push_back('{id: 1'b0, data: 32'h55});
    tick();
    r0_read = 1'b0;
    test_read_responses(1);
  endtask

  task automatic test_full_fifo();
    exp_t e;
    r0_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r0_address = 32'h300 + 32'(4 * k);
      sb.push_back('{id: 1'b0, data: 32'h60 + 32'(k)});
      tick();
    end
    r0_address = 32'h400;
    r1_write = 1'b1; r1_address = 32'h500; r1_writedata = 32'h1234;
    @(negedge clk);
    n_cmp += 3;
    if (pend_count !== 3'd4) begin n_err++; $display("FAIL full_pend got %0d want 4", pend_count); end
    if ({r0_waitrequest, d_read} !== 2'b10) begin
      n_err++; $display("FAIL full_r0_held got %b want 10", {r0_waitrequest, d_read});
    end
    if ({d_write, r1_waitrequest} !== 2'b10) begin
      n_err++; $display("FAIL full_r1_write got %b want 10", {d_write, r1_waitrequest});
    end
    tick();
    r1_write = 1'b0;
    d_readdatavalid = 1'b1; d_readdata = sb[0].data;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp += 2;
    if ({r0_readdatavalid, r0_readdata} !== {1'b1, e.data}) begin
      n_err++; $display("FAIL full_rsp got %b/%h want 1/%h", r0_readdatavalid, r0_readdata, e.data);
    end
    if ({r0_waitrequest, d_read} !== 2'b10) begin
      n_err++; $display("FAIL full_still_held got %b want 10", {r0_waitrequest, d_read});
    end
    tick();
    d_readdatavalid = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if ({r0_waitrequest, d_read} !== 2'b01) begin
      n_err++; $display("FAIL full_5th_issue got %b want 01", {r0_waitrequest, d_read});
    end
    if (d_address !== 32'h400) begin n_err++; $display("FAIL full_5th_addr got %h want 400", d_address); end
    sb.push_back('{id: 1'b0, data: 32'h70});
    tick();
    r0_read = 1'b0;
    test_read_responses(4);
  endtask

  task automatic test_push_pop();
    exp_t e;
    r0_read = 1'b1; r0_address = 32'h700;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{id: 1'b0, data: 32'h80 + 32'(k)});
      tick();
    end
    r0_read = 1'b0;
    r1_read = 1'b1; r1_address = 32'h600;
    d_readdatavalid = 1'b1; d_readdata = sb[0].data;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp += 3;
    if (pend_count !== 3'd2) begin n_err++; $display("FAIL pp_pend_before got %0d want 2", pend_count); end
    if ({r0_readdatavalid, r0_readdata} !== {1'b1, e.data}) begin
      n_err++; $display("FAIL pp_rsp got %b/%h want 1/%h", r0_readdatavalid, r0_readdata, e.data);
    end
    if ({d_read, r1_waitrequest} !== 2'b10) begin
      n_err++; $display("FAIL pp_r1_read got %b want 10", {d_read, r1_waitrequest});
    end
    sb.push_back('{id: 1'b1, data: 32'h82});
    tick();
    r1_read = 1'b0; d_readdatavalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pend_count !== 3'd2) begin n_err++; $display("FAIL pp_pend_after got %0d want 2", pend_count); end
    tick();
    test_read_responses(2);
    @(negedge clk);
    n_cmp += 2;
    if (pend_count !== 3'd0) begin n_err++; $display("FAIL pp_drained got %0d want 0", pend_count); end
    if (err_spurious_rdv !== 1'b0) begin n_err++; $display("FAIL spur_pre got %b want 0", err_spurious_rdv); end
    tick();
    d_readdatavalid = 1'b1; d_readdata = 32'h99;
    @(negedge clk);
    n_cmp++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      n_err++; $display("FAIL spur_route got %b want 00", {r0_readdatavalid, r1_readdatavalid});
    end
    tick();
    d_readdatavalid = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (err_spurious_rdv !== 1'b1) begin n_err++; $display("FAIL spur_flag got %b want 1", err_spurious_rdv); end
    if (pend_count !== 3'd0) begin n_err++; $display("FAIL spur_pend got %0d want 0", pend_count); end
    tick();
  endtask

`ifdef JTG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   cyc;
    bit   seen = 1'b0;
    r0_read = 1'b1; r0_address = 32'h900;
    d_waitrequest = 1'b1;
    sb.push_back('{id: 1'b0, data: 32'hDEADBEEF});
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (timeout_evt === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    n_cmp += 2;
    if (!seen || cyc != 16) begin n_err++; $display("FAIL to_evt got cyc=%0d seen=%b want 16", cyc, seen); end
    if ({r0_waitrequest, d_read} !== 2'b00) begin
      n_err++; $display("FAIL to_release got %b want 00", {r0_waitrequest, d_read});
    end
    tick();
    r0_read = 1'b0;
    r1_write = 1'b1; r1_address = 32'hA00;
    d_waitrequest = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp += 2;
    if ({r0_readdatavalid, r0_readdata} !== {1'b1, e.data}) begin
      n_err++; $display("FAIL to_rsp got %b/%h want 1/%h", r0_readdatavalid, r0_readdata, e.data);
    end
    if ({d_write, r1_waitrequest} !== 2'b10) begin
      n_err++; $display("FAIL to_r1_grant got %b want 10", {d_write, r1_waitrequest});
    end
    tick();
    r1_write = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    r0_address = '0; r0_read = 1'b0; r0_write = 1'b0; r0_writedata = '0; r0_byteenable = 4'hF;
    r1_address = '0; r1_read = 1'b0; r1_write = 1'b0; r1_writedata = '0; r1_byteenable = 4'hF;
    d_waitrequest = 1'b0; d_readdata = '0; d_readdatavalid = 1'b0;
    test_reset();
    test_contention();
    test_lock();
    test_full_fifo();
    test_push_pop();
`ifdef JTG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
